// File: rtl/alu_operand_regfile_if.sv
// Handshake/bus bundle between the issue logic and the operand stage.
// master drives read/write requests, slave returns the captured operands.
interface alu_operand_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              operand_valid;

    modport master (
        output stall, rd_en, rs_addr, rt_addr,
        output we, wr_addr, wr_data,
        input  operand1, operand2, operand_valid
    );

    modport slave (
        input  stall, rd_en, rs_addr, rt_addr,
        input  we, wr_addr, wr_data,
        output operand1, operand2, operand_valid
    );
endinterface

// File: rtl/alu_operand_regfile.sv
// Integer register file with a registered operand stage feeding the ALU.
// Optional: define REGFILE_WRITE_BYPASS_EN for write-before-read capture.
module alu_operand_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_regfile_if.slave bus
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_valid;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    // r0 is never a write target
    assign w_wr_ok = bus.we && (bus.wr_addr != '0);

    // Read mux: r0 reads as zero, optional forward from the write port
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (bus.rs_addr != '0) begin
            w_rs_val = r_regs[bus.rs_addr];
        end
        if (bus.rt_addr != '0) begin
            w_rt_val = r_regs[bus.rt_addr];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_ok && (bus.wr_addr == bus.rs_addr)) begin
            w_rs_val = bus.wr_data;
        end
        if (w_wr_ok && (bus.wr_addr == bus.rt_addr)) begin
            w_rt_val = bus.wr_data;
        end
`endif
    end

    // Register array: sync clear, single write port independent of stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Operand stage: reset > stall hold > capture on rd_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.rd_en) begin
                r_op1   <= w_rs_val;
                r_op2   <= w_rt_val;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.operand1      = r_op1;
    assign bus.operand2      = r_op2;
    assign bus.operand_valid = r_valid;
endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Integer register file plus registered operand stage directly upstream of the 32-bit ALU.
- Holds the architectural registers and drives the ALU's two operand inputs (input1, input2) from a registered read stage.
- Has one synchronous write port, fed from the writeback path.
- Provides a stall hold so operands stay stable while the ALU/control stage is busy.

Parameters:
- DATA_W, 32, width of each register and operand; matches the ALU data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  1 = hold operand outputs and operand_valid unchanged.
- rd_en  input  1  request a read of rs_addr/rt_addr this cycle.
- rs_addr  input  ADDR_W  source register for operand1.
- rt_addr  input  ADDR_W  source register for operand2.
- we  input  1  write enable.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  DATA_W  write data.
- operand1  output  DATA_W  registered value of rs; drives ALU input1.
- operand2  output  DATA_W  registered value of rt; drives ALU input2.
- operand_valid  output  1  operand1/operand2 hold a completed read.

Behaviour:
- One clock; reset is synchronous and active-low.
  - Reset acts only on a rising clk edge with rst_n=0.
  - Clears all NUM_REGS registers to 0.
  - Clears operand1, operand2 and operand_valid to 0.
  - A write presented in the reset cycle is discarded.
- Register 0 is hardwired to zero:
  - writes with wr_addr=0 are ignored;
  - reads of address 0 return 0.
- Write:
  - at posedge with rst_n=1 and we=1 and wr_addr!=0, regs[wr_addr] <= wr_data;
  - the write is independent of stall and rd_en.
- Read stage, latency 1 cycle; priority is reset > stall > rd_en:
  - stall=1: operand1, operand2 and operand_valid hold their values. rd_en is ignored and the request is not queued; the requester must re-present it.
  - stall=0, rd_en=1: operand1 <= value(rs_addr), operand2 <= value(rt_addr), operand_valid <= 1.
  - stall=0, rd_en=0: operand_valid <= 0; operand1/operand2 hold their last values.
- Both ports may read the same address in one cycle; both return the same value.
- Same-cycle write and read of the same nonzero address: result is defined under Optional Feature.
- Write during stall to a register already captured in operand1/2 does not change the captured operand.
- Out-of-range addresses cannot occur because NUM_REGS=2**ADDR_W.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if we=1, wr_addr!=0, stall=0 and rd_en=1 in the same cycle, and wr_addr matches rs_addr and/or rt_addr, the matching operand captures wr_data. The register is also written as normal. This gives write-before-read semantics.
- Undefined: the matching operand captures the old register contents, i.e. read-before-write. The new value is visible on the next read.
- Address 0 is never bypassed in either build.

Test Plan:
- Reset, then rd_en=1 with rs=5, rt=9 -> next cycle operand1=0, operand2=0, operand_valid=1.
- Write r1=15 and r2=42 in consecutive cycles, then read rs=1, rt=2 -> operand1=15, operand2=42 one cycle later. The ALU then sees input1=0x0F, input2=0x2A.
- Write r0=0xDEADBEEF, then read rs=0, rt=0 -> both operands 0.
- Read r1/r2 (15/42) with stall=1 for 3 cycles while writing r1=7 and presenting rs=3 -> operands stay 15/42 and valid stays 1. Release stall and re-read rs=1 -> operand1=7.
- Same cycle: write r3=0xFFFFFFFD (-3) and read rs=3, rt=3, with r3 previously 8 -> with REGFILE_WRITE_BYPASS_EN both operands are 0xFFFFFFFD; without it both are 8.
- Reset asserted mid-stream with we=1 to r4=99 -> all operands 0 and valid 0. A subsequent read of r1, r2 and r4 returns 0 each.
